// File: rtl/osc_bank.sv
// osc_bank: byte-command square-wave oscillator bank with an active-channel PWM output.
// Define OSC_BANK_RUNNING_STATUS_EN to let bare data bytes reuse the last note-on channel.
module osc_bank #(
  parameter int unsigned NUM_CH    = 7,
  parameter int unsigned DIV_SHIFT = 4
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              cmdValid_i,
  input  logic [7:0]        cmdData_i,
  output logic [NUM_CH-1:0] oscOut_o,
  output logic              activeOscPwm_o
);

  localparam int unsigned CntW = 7 + DIV_SHIFT;
  localparam int unsigned PW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [0:0] {StIdle, StWaitData} state_e;

  state_e     state_q, state_d;
  logic [3:0] ch_q, ch_d;

  // Decoded command actions for this cycle
  logic       on_vld;
  logic [3:0] on_ch;
  logic [6:0] on_div;
  logic       off_vld;
  logic       all_off;
  logic [3:0] cmd_ch;
  logic       is_status;

  logic                          unused_cmd;
  logic [NUM_CH-1:0]             active_q, active_d;
  logic [NUM_CH-1:0][6:0]        div_q, div_d;
  logic [NUM_CH-1:0][CntW-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]             out_q, out_d;
  logic [CntW:0]                 half;
  logic [PW-1:0]                 p_q, p_d;
  logic                          pwm_q, pwm_d;
  logic [4:0]                    n_act;

`ifdef OSC_BANK_RUNNING_STATUS_EN
  logic       rs_valid_q, rs_valid_d;
  logic [3:0] rs_ch_q, rs_ch_d;
`endif

  assign unused_cmd = cmdData_i[4];
  assign cmd_ch     = cmdData_i[3:0];
  assign is_status  = cmdData_i[7];

  // Parser: a status byte always resolves immediately, even while a note-on is pending.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    on_vld  = 1'b0;
    on_ch   = ch_q;
    on_div  = cmdData_i[6:0];
    off_vld = 1'b0;
    all_off = 1'b0;
`ifdef OSC_BANK_RUNNING_STATUS_EN
    rs_valid_d = rs_valid_q;
    rs_ch_d    = rs_ch_q;
`endif
    if (cmdValid_i) begin
      if (is_status) begin
        state_d = StIdle;
        case (cmdData_i[6:5])
          2'b00: begin
            off_vld = 1'b1;
`ifdef OSC_BANK_RUNNING_STATUS_EN
            rs_valid_d = 1'b0;
`endif
          end
          2'b01: begin
            state_d = StWaitData;
            ch_d    = cmd_ch;
`ifdef OSC_BANK_RUNNING_STATUS_EN
            rs_valid_d = 1'b1;
            rs_ch_d    = cmd_ch;
`endif
          end
          2'b10: begin
            all_off = 1'b1;
`ifdef OSC_BANK_RUNNING_STATUS_EN
            rs_valid_d = 1'b0;
`endif
          end
          default: begin
`ifdef OSC_BANK_RUNNING_STATUS_EN
            rs_valid_d = 1'b0;
`endif
          end
        endcase
      end else if (state_q == StWaitData) begin
        on_vld  = 1'b1;
        on_ch   = ch_q;
        state_d = StIdle;
      end else begin
`ifdef OSC_BANK_RUNNING_STATUS_EN
        if (rs_valid_q) begin
          on_vld = 1'b1;
          on_ch  = rs_ch_q;
        end
`endif
      end
    end
  end

  // Channels: out-of-range channel numbers simply never match an index.
  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    half     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      half = ((CntW+1)'(div_q[i]) + (CntW+1)'(1)) << DIV_SHIFT;
      if (all_off || (off_vld && cmd_ch == 4'(i)) ||
          (on_vld && on_ch == 4'(i) && on_div == 7'd0)) begin
        active_d[i] = 1'b0;
        cnt_d[i]    = '0;
        out_d[i]    = 1'b0;
      end else if (on_vld && on_ch == 4'(i)) begin
        active_d[i] = 1'b1;
        div_d[i]    = on_div;
        cnt_d[i]    = '0;
        out_d[i]    = 1'b1;
      end else if (active_q[i]) begin
        if (cnt_q[i] == CntW'(half - (CntW+1)'(1))) begin
          cnt_d[i] = '0;
          out_d[i] = ~out_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // PWM compares against the registered active set, so it lags a change by one cycle.
  always_comb begin
    n_act = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_act = n_act + 5'(active_q[i]);
    end
    p_d   = (p_q == PW'(NUM_CH - 1)) ? '0 : p_q + PW'(1);
    pwm_d = (5'(p_q) < n_act);
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      active_q <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      p_q      <= '0;
      pwm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      active_q <= active_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      p_q      <= p_d;
      pwm_q    <= pwm_d;
    end
  end

`ifdef OSC_BANK_RUNNING_STATUS_EN
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      rs_valid_q <= 1'b0;
      rs_ch_q    <= '0;
    end else begin
      rs_valid_q <= rs_valid_d;
      rs_ch_q    <= rs_ch_d;
    end
  end
`endif

  assign oscOut_o       = out_q;
  assign activeOscPwm_o = pwm_q;

endmodule

// File: tb/tb_osc_bank.sv
// tb_osc_bank: directed and random command stream against a time-based reference model.
module tb_osc_bank;

  localparam int NUM_CH    = 7;
  localparam int DIV_SHIFT = 4;
`ifdef OSC_BANK_RUNNING_STATUS_EN
  localparam bit RS_EN = 1'b1;
`else
  localparam bit RS_EN = 1'b0;
`endif

  logic              clk;
  logic              nrst;
  logic              cmd_valid;
  logic [7:0]        cmd_data;
  logic [NUM_CH-1:0] osc_out;
  logic              pwm_out;

  int vectors;
  int miscompares;

  osc_bank #(
    .NUM_CH   (NUM_CH),
    .DIV_SHIFT(DIV_SHIFT)
  ) u_dut (
    .clk_i         (clk),
    .nrst_i        (nrst),
    .cmdValid_i    (cmd_valid),
    .cmdData_i     (cmd_data),
    .oscOut_o      (osc_out),
    .activeOscPwm_o(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a channel's level follows from when it was keyed and its half-period.
  bit m_act[16];
  int m_half[16];
  int m_start[16];
  int m_cyc;
  int m_pend;
  int m_rs;
  int m_pop_prev;
  bit m_pwm;

  function automatic bit exp_out(input int i);
    if (!m_act[i]) return 1'b0;
    return (((m_cyc - m_start[i]) / m_half[i]) % 2) == 0;
  endfunction

  function automatic void m_note_on(input int ch, input int d);
    if (ch >= NUM_CH) return;
    if (d == 0) begin
      m_act[ch] = 1'b0;
    end else begin
      m_act[ch]   = 1'b1;
      m_half[ch]  = (d + 1) << DIV_SHIFT;
      m_start[ch] = m_cyc;
    end
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 16; i++) begin
        m_act[i]   = 1'b0;
        m_half[i]  = 1;
        m_start[i] = 0;
      end
      m_cyc      = 0;
      m_pend     = -1;
      m_rs       = -1;
      m_pop_prev = 0;
      m_pwm      = 1'b0;
    end else begin
      m_cyc = m_cyc + 1;
      m_pwm = ((m_cyc - 1) % NUM_CH) < m_pop_prev;
      if (cmd_valid) begin
        if (cmd_data[7]) begin
          m_pend = -1;
          case (cmd_data[6:5])
            2'd0: begin
              if (int'(cmd_data[3:0]) < NUM_CH) m_act[cmd_data[3:0]] = 1'b0;
              m_rs = -1;
            end
            2'd1: begin
              m_pend = int'(cmd_data[3:0]);
              m_rs   = int'(cmd_data[3:0]);
            end
            2'd2: begin
              for (int i = 0; i < 16; i++) m_act[i] = 1'b0;
              m_rs = -1;
            end
            default: m_rs = -1;
          endcase
        end else if (m_pend >= 0) begin
          m_note_on(m_pend, int'(cmd_data[6:0]));
          m_pend = -1;
        end else if (RS_EN && m_rs >= 0) begin
          m_note_on(m_rs, int'(cmd_data[6:0]));
        end
      end
      m_pop_prev = 0;
      for (int i = 0; i < NUM_CH; i++) m_pop_prev += int'(m_act[i]);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  bit check_en;

  always @(negedge clk) begin
    if (check_en && nrst) begin
      for (int i = 0; i < NUM_CH; i++) chk($sformatf("osc[%0d]", i), int'(osc_out[i]),
                                            int'(exp_out(i)));
      chk("pwm", int'(pwm_out), int'(m_pwm));
    end
  end

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  int highs;
  int r;
  int d;

  initial begin
    vectors     = 0;
    miscompares = 0;
    check_en    = 1'b0;
    cmd_valid   = 1'b0;
    cmd_data    = 8'h00;
    nrst        = 1'b1;
    #2 nrst     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset osc", int'(osc_out), 0);
    chk("reset pwm", int'(pwm_out), 0);
    nrst     = 1'b1;
    check_en = 1'b1;

    // Note-on ch2 d=3: half-period 64
    drive(8'hA2); drive(8'h03); idle(1);
    chk("ch2 on", int'(osc_out), 32'h4);
    idle(63);
    chk("ch2 before toggle", int'(osc_out[2]), 1);
    idle(1);
    chk("ch2 first toggle", int'(osc_out[2]), 0);
    idle(64);
    chk("ch2 second toggle", int'(osc_out[2]), 1);

    // Retune to d=7 restarts phase: half-period 128
    idle(10);
    drive(8'hA2); drive(8'h07); idle(1);
    chk("ch2 retune", int'(osc_out[2]), 1);
    idle(127);
    chk("ch2 retune hold", int'(osc_out[2]), 1);
    idle(1);
    chk("ch2 retune toggle", int'(osc_out[2]), 0);
    drive(8'h82); idle(1);
    chk("ch2 off", int'(osc_out[2]), 0);

    // PWM with three of seven channels
    drive(8'hA0); drive(8'h01); drive(8'hA1); drive(8'h01); drive(8'hA5); drive(8'h01);
    idle(1);
    highs = 0;
    for (int k = 0; k < 7; k++) begin
      idle(1);
      highs += int'(pwm_out);
    end
    chk("pwm 3 of 7", highs, 3);
    drive(8'hC0); idle(2);
    highs = 0;
    for (int k = 0; k < 14; k++) begin
      idle(1);
      highs += int'(pwm_out);
    end
    chk("pwm all-off", highs, 0);
    chk("all-off osc", int'(osc_out), 0);

    // All channels on: PWM constant high
    for (int c = 0; c < NUM_CH; c++) begin
      drive(8'hA0 | 8'(c)); drive(8'h02);
    end
    idle(2);
    highs = 0;
    for (int k = 0; k < 14; k++) begin
      idle(1);
      highs += int'(pwm_out);
    end
    chk("pwm all-on", highs, 14);
    drive(8'hC0); idle(2);

    // Boundaries
    drive(8'hA9); drive(8'h05); idle(1);
    chk("ch9 ignored", int'(osc_out), 0);
    drive(8'hA3); drive(8'h05); idle(1);
    chk("ch3 on", int'(osc_out[3]), 1);
    drive(8'hA3); drive(8'h00); idle(1);
    chk("d=0 off", int'(osc_out[3]), 0);
    drive(8'hA1); drive(8'h81); drive(8'h05); idle(1);
    chk("aborted note-on", int'(osc_out[1]), 0);

    // Running status
    drive(8'hA4); drive(8'h05); idle(1);
    drive(8'h09); idle(1);
    idle(100);
    chk("running status", int'(osc_out[4]), RS_EN ? 1 : 0);
    drive(8'hC0); idle(2);

    // Async reset mid-toggle, then quiet for 1000 cycles
    drive(8'hA0); drive(8'h01); drive(8'hA6); drive(8'h02); idle(40);
    @(negedge clk);
    #3 nrst = 1'b0;
    #1;
    chk("async reset osc", int'(osc_out), 0);
    chk("async reset pwm", int'(pwm_out), 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    idle(1000);
    chk("quiet after reset", int'(osc_out), 0);

    // Reset discards a half-received note-on
    drive(8'hA6);
    @(negedge clk);
    cmd_valid = 1'b0;
    #3 nrst = 1'b0;
    #1 nrst = 1'b1;
    drive(8'h05); idle(1);
    chk("pending discarded", int'(osc_out[6]), 0);

    // Random command stream
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 19);
      d = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 5) : $urandom_range(0, 127);
      if (r < 6)       cmd_data = 8'hA0 | 8'($urandom_range(0, 31));
      else if (r < 8)  cmd_data = 8'h80 | 8'($urandom_range(0, 31));
      else if (r < 9)  cmd_data = 8'hC0 | 8'($urandom_range(0, 31));
      else if (r < 10) cmd_data = 8'hE0 | 8'($urandom_range(0, 31));
      else             cmd_data = 8'(d);
    end
    idle(50);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
